mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between I-cache block fills, D-cache
// block fills and D-cache write-throughs.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   i_req, i_addr                I-cache fill request and miss address
//   d_req, d_addr                D-cache fill request and miss address
//   d_wr_req, d_wr_addr/data     D-cache write-through request
//   mem_data_out, mem_data_valid memory read return
//   mem_en, mem_wr, mem_addr,
//   mem_wdata                    memory command
//   i_busy, d_busy               transaction-in-progress flags
//   fill_data                    read data forwarded to both caches
//   i_data_vld, d_data_vld       fill word strobes
//   i_done, d_done, d_wr_ack     one-cycle completion pulses
module mem_arbiter #(
    parameter int unsigned WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic [15:0] d_addr,
    input  logic        d_wr_req,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    input  logic [15:0] mem_data_out,
    input  logic        mem_data_valid,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        i_busy,
    output logic        d_busy,
    output logic [15:0] fill_data,
    output logic        i_data_vld,
    output logic        d_data_vld,
    output logic        i_done,
    output logic        d_done,
    output logic        d_wr_ack
);

    localparam logic [3:0] WordCount = 4'(WORDS);
    localparam logic [3:0] LastWord  = 4'(WORDS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIFill,
        StDFill,
        StDWrite
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  issue_cnt_q, issue_cnt_d;
    logic [3:0]  rx_cnt_q, rx_cnt_d;
    logic [11:0] base_q, base_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;

    logic in_fill;
    logic issuing;
    logic fill_vld;
    logic fill_done;

    // Valids outside a fill or past the last word are dropped entirely.
    always_comb begin
        in_fill   = (state_q == StIFill) || (state_q == StDFill);
        issuing   = in_fill && (issue_cnt_q < WordCount);
        fill_vld  = in_fill && mem_data_valid && (rx_cnt_q < WordCount);
        fill_done = fill_vld && (rx_cnt_q == LastWord);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            issue_cnt_q <= '0;
            rx_cnt_q    <= '0;
            base_q      <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            base_q      <= base_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        base_d      = base_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        unique case (state_q)
            StIdle: begin
                issue_cnt_d = '0;
                rx_cnt_d    = '0;
                if (i_req) begin
                    state_d = StIFill;
                    base_d  = i_addr[15:4];
                end else if (d_req) begin
                    state_d = StDFill;
                    base_d  = d_addr[15:4];
                end else if (d_wr_req) begin
                    state_d   = StDWrite;
                    wr_addr_d = d_wr_addr;
                    wr_data_d = d_wr_data;
                end
            end
            StIFill, StDFill: begin
                if (issuing) begin
                    issue_cnt_d = issue_cnt_q + 4'd1;
                end
                if (fill_vld) begin
                    rx_cnt_d = rx_cnt_q + 4'd1;
                end
                if (fill_done) begin
                    state_d     = StIdle;
                    issue_cnt_d = '0;
                    rx_cnt_d    = '0;
                end
            end
            StDWrite: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = 16'h0000;
        mem_wdata  = 16'h0000;
        i_busy     = 1'b0;
        d_busy     = 1'b0;
        i_data_vld = 1'b0;
        d_data_vld = 1'b0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        d_wr_ack   = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StIFill: begin
                i_busy     = 1'b1;
                mem_en     = issuing;
                mem_addr   = issuing ? {base_q, issue_cnt_q[2:0], 1'b0} : 16'h0000;
                i_data_vld = fill_vld;
                i_done     = fill_done;
            end
            StDFill: begin
                d_busy     = 1'b1;
                mem_en     = issuing;
                mem_addr   = issuing ? {base_q, issue_cnt_q[2:0], 1'b0} : 16'h0000;
                d_data_vld = fill_vld;
                d_done     = fill_done;
            end
            StDWrite: begin
                d_busy    = 1'b1;
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = wr_addr_q;
                mem_wdata = wr_data_q;
                d_wr_ack  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign fill_data = mem_data_out;

endmodule
